// File: rtl/uart_tx_ctrl_if.sv
// Byte-write / serial-status bundle between the main controller and the UART transmitter.
// Pure wiring, no latency.
// No backpressure on txrdy; the writer watches full/ovr to pace itself.
interface uart_tx_ctrl_if;
  logic [7:0] txdw;
  logic       txrdy;
  logic       tx;
  logic       busy;
  logic       full;
  logic       done;
  logic       ovr;

  modport master (
    output txdw, txrdy,
    input  tx, busy, full, done, ovr
  );

  modport slave (
    input  txdw, txrdy,
    output tx, busy, full, done, ovr
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one stop bit, one-byte holding register.
// Latency: write strobe at an edge -> start bit on tx from that same edge; each bit lasts BAUD_DIV cycles.
// No stall: a write while the holding register is occupied is dropped and raises the sticky ovr flag.
module uart_tx_ctrl #(
  parameter int BAUD_DIV = 5208,
  parameter int PARITY   = 0
) (
  input logic            clk,
  input logic            rst,
  uart_tx_ctrl_if.slave  link
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    hold;
  logic          par;
  logic          tx_q;
  logic          busy_q;
  logic          full_q;
  logic          done_q;
  logic          ovr_q;

  logic bit_end;
  logic hand_off;

  // Parity of the byte being loaded; odd parity is the complement of even.
  function automatic logic parity_of(input logic [7:0] b);
    return (PARITY == 2) ? ~^b : ^b;
  endfunction

  assign bit_end  = (cnt == CNT_MAX);
  assign hand_off = (state == S_STOP) && bit_end;

  assign link.tx   = tx_q;
  assign link.busy = busy_q;
  assign link.full = full_q;
  assign link.done = done_q;
  assign link.ovr  = ovr_q;

  // Frame sequencer, bit timer, holding register and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      hold   <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      full_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt    <= bit_end ? '0 : cnt + 1'b1;

      // Writes during a frame go to the holding register. A write landing on
      // the stop-bit hand-off refills the slot being emptied; a write landing
      // there with the slot empty is loaded straight into the shifter below.
      if (link.txrdy && state != S_IDLE) begin
        if (full_q) begin
          if (hand_off) hold  <= link.txdw;
          else          ovr_q <= 1'b1;
        end else if (!hand_off) begin
          hold   <= link.txdw;
          full_q <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (full_q) begin
            state  <= S_START;
            shreg  <= hold;
            par    <= parity_of(hold);
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
            full_q <= link.txrdy;
            if (link.txrdy) hold <= link.txdw;
          end else if (link.txrdy) begin
            state  <= S_START;
            shreg  <= link.txdw;
            par    <= parity_of(link.txdw);
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            idx   <= '0;
            tx_q  <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx == 3'd7) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
              tx_q  <= (PARITY != 0) ? par : 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              shreg <= shreg >> 1;
              tx_q  <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx_q  <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            done_q <= 1'b1;
            if (full_q) begin
              state  <= S_START;
              shreg  <= hold;
              par    <= parity_of(hold);
              tx_q   <= 1'b0;
              full_q <= link.txrdy;
            end else if (link.txrdy) begin
              state <= S_START;
              shreg <= link.txdw;
              par   <= parity_of(link.txdw);
              tx_q  <= 1'b0;
            end else begin
              state  <= S_IDLE;
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with BAUD_DIV=4 and all three parity settings.
// Samples 1 time unit after each rising edge; expected frames are hand-built bit sequences.
// Drives txrdy as single-cycle strobes and scrambles txdw right after each strobe.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if ifa ();
  uart_tx_ctrl_if ifb ();
  uart_tx_ctrl_if ifc ();

  uart_tx_ctrl #(.BAUD_DIV(4), .PARITY(0)) u_p0 (.clk(clk), .rst(rst), .link(ifa.slave));
  uart_tx_ctrl #(.BAUD_DIV(4), .PARITY(1)) u_p1 (.clk(clk), .rst(rst), .link(ifb.slave));
  uart_tx_ctrl #(.BAUD_DIV(4), .PARITY(2)) u_p2 (.clk(clk), .rst(rst), .link(ifc.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot i of a frame: start, D0..D7, [parity], stop.
  function automatic logic fbit(input logic [7:0] b, input logic has_par,
                                input logic pbit, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (has_par && i == 9) return pbit;
    return 1'b1;
  endfunction

  task automatic send_a(input logic [7:0] b);
    ifa.txrdy = 1'b1;
    ifa.txdw  = b;
    step();
    ifa.txrdy = 1'b0;
    ifa.txdw  = ~b;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    ifa.txrdy = 1'b0; ifb.txrdy = 1'b0; ifc.txrdy = 1'b0;
    ifa.txdw  = 8'h00; ifb.txdw = 8'h00; ifc.txdw = 8'h00;
    rst = 1'b0;
    repeat (3) step();
    obs = {ifa.tx, ifa.busy, ifa.full, ifa.done, ifa.ovr,
           ifb.tx, ifb.busy, ifb.full, ifb.done, ifb.ovr,
           ifc.tx, ifc.busy, ifc.full, ifc.done, ifc.ovr};
    total++;
    if (obs !== {3{5'b10000}}) begin
      bad++;
      $display("FAIL reset_held got %b want %b", obs, {3{5'b10000}});
    end
    rst = 1'b1;
    repeat (2) step();
    obs = {ifa.tx, ifa.busy, ifa.full, ifa.done, ifa.ovr,
           ifb.tx, ifb.busy, ifb.full, ifb.done, ifb.ovr,
           ifc.tx, ifc.busy, ifc.full, ifc.done, ifc.ovr};
    total++;
    if (obs !== {3{5'b10000}}) begin
      bad++;
      $display("FAIL reset_release got %b want %b", obs, {3{5'b10000}});
    end
  endtask

  task automatic test_basic();
    logic [9:0] seq;
    logic [2:0] obs, exp;
    seq = 10'b1111100000;  // slot 0 = start, slots 1..8 = F0 LSB first, slot 9 = stop
    send_a(8'hF0);
    for (int k = 0; k <= 41; k++) begin
      exp = (k < 40) ? {seq[k/4], 1'b1, 1'b0} : {1'b1, 1'b0, (k == 40)};
      obs = {ifa.tx, ifa.busy, ifa.done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL basic k=%0d {tx,busy,done} got %b want %b", k, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_parity();
    logic [5:0] obs, exp;
    ifb.txrdy = 1'b1; ifb.txdw = 8'h0F;
    ifc.txrdy = 1'b1; ifc.txdw = 8'h0F;
    step();
    ifb.txrdy = 1'b0; ifb.txdw = 8'hA5;
    ifc.txrdy = 1'b0; ifc.txdw = 8'hA5;
    for (int k = 0; k <= 45; k++) begin
      if (k < 44)
        exp = {fbit(8'h0F, 1'b1, 1'b0, k/4), 1'b1, 1'b0,
               fbit(8'h0F, 1'b1, 1'b1, k/4), 1'b1, 1'b0};
      else
        exp = {1'b1, 1'b0, (k == 44), 1'b1, 1'b0, (k == 44)};
      obs = {ifb.tx, ifb.busy, ifb.done, ifc.tx, ifc.busy, ifc.done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL parity k=%0d {even tx,busy,done,odd tx,busy,done} got %b want %b", k, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    logic       t;
    send_a(8'hF0);
    for (int k = 0; k <= 81; k++) begin
      if (k < 40)      t = fbit(8'hF0, 1'b0, 1'b0, k/4);
      else if (k < 80) t = fbit(8'h0F, 1'b0, 1'b0, (k-40)/4);
      else             t = 1'b1;
      exp = {t, (k < 80), (k == 40 || k == 80), (k >= 5 && k < 40)};
      obs = {ifa.tx, ifa.busy, ifa.done, ifa.full};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL b2b k=%0d {tx,busy,done,full} got %b want %b", k, obs, exp);
      end
      if (k == 4) begin ifa.txrdy = 1'b1; ifa.txdw = 8'h0F; end
      if (k == 5) begin ifa.txrdy = 1'b0; ifa.txdw = 8'h00; end
      step();
    end
    total++;
    if (ifa.ovr !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ovr got %b want 0", ifa.ovr);
    end
  endtask

  task automatic test_last_stop();
    logic [2:0] obs, exp;
    logic       t;
    send_a(8'h5A);
    for (int k = 0; k <= 81; k++) begin
      if (k < 40)      t = fbit(8'h5A, 1'b0, 1'b0, k/4);
      else if (k < 80) t = fbit(8'hC3, 1'b0, 1'b0, (k-40)/4);
      else             t = 1'b1;
      exp = {t, (k < 80), (k == 40 || k == 80)};
      obs = {ifa.tx, ifa.busy, ifa.done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL last_stop k=%0d {tx,busy,done} got %b want %b", k, obs, exp);
      end
      if (k == 39) begin ifa.txrdy = 1'b1; ifa.txdw = 8'hC3; end
      if (k == 40) begin ifa.txrdy = 1'b0; ifa.txdw = 8'h3C; end
      step();
    end
    total++;
    if (ifa.ovr !== 1'b0) begin
      bad++;
      $display("FAIL last_stop_ovr got %b want 0", ifa.ovr);
    end
  endtask

  task automatic test_overrun();
    logic [4:0] obs, exp;
    logic       t;
    send_a(8'h3C);
    for (int k = 0; k <= 85; k++) begin
      if (k < 40)      t = fbit(8'h3C, 1'b0, 1'b0, k/4);
      else if (k < 80) t = fbit(8'h81, 1'b0, 1'b0, (k-40)/4);
      else             t = 1'b1;
      exp = {t, (k < 80), (k == 40 || k == 80), (k >= 3 && k < 40), (k >= 7)};
      obs = {ifa.tx, ifa.busy, ifa.done, ifa.full, ifa.ovr};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL overrun k=%0d {tx,busy,done,full,ovr} got %b want %b", k, obs, exp);
      end
      if (k == 2) begin ifa.txrdy = 1'b1; ifa.txdw = 8'h81; end
      if (k == 3) begin ifa.txrdy = 1'b0; ifa.txdw = 8'h00; end
      if (k == 6) begin ifa.txrdy = 1'b1; ifa.txdw = 8'hAA; end
      if (k == 7) begin ifa.txrdy = 1'b0; ifa.txdw = 8'h00; end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [4:0] obs;
    logic [3:0] idle, fr, exp;
    send_a(8'h96);
    for (int k = 0; k < 15; k++) begin
      if (k == 3) begin ifa.txrdy = 1'b1; ifa.txdw = 8'h11; end
      if (k == 4) begin ifa.txrdy = 1'b0; ifa.txdw = 8'h00; end
      step();
    end
    pre = {ifa.busy, ifa.full, ifa.ovr};
    total++;
    if (pre !== 3'b111) begin
      bad++;
      $display("FAIL reset_mid_pre {busy,full,ovr} got %b want 111", pre);
    end
    rst = 1'b0;
    step();
    obs = {ifa.tx, ifa.busy, ifa.full, ifa.done, ifa.ovr};
    total++;
    if (obs !== 5'b10000) begin
      bad++;
      $display("FAIL reset_mid {tx,busy,full,done,ovr} got %b want 10000", obs);
    end
    rst = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      idle = {ifa.tx, ifa.busy, ifa.done, ifa.full};
      total++;
      if (idle !== 4'b1000) begin
        bad++;
        $display("FAIL reset_mid_idle k=%0d {tx,busy,done,full} got %b want 1000", k, idle);
      end
    end
    send_a(8'h3A);
    for (int k = 0; k <= 41; k++) begin
      exp = (k < 40) ? {fbit(8'h3A, 1'b0, 1'b0, k/4), 1'b1, 1'b0, 1'b0}
                     : {1'b1, 1'b0, (k == 40), 1'b0};
      fr = {ifa.tx, ifa.busy, ifa.done, ifa.ovr};
      total++;
      if (fr !== exp) begin
        bad++;
        $display("FAIL reset_mid_resend k=%0d {tx,busy,done,ovr} got %b want %b", k, fr, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_last_stop();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit path of the board link: serialises response bytes produced by the main controller back to the host, mirroring the receive side's `rxdw`/`rxrdy` byte handshake with a `txdw`/`txrdy` pair. One frame is 8N1 by default, with optional parity. A one-byte holding register accepts a second byte while a frame is in flight, so frames go out back-to-back with no idle gap.

## Interface
- `BAUD_DIV`, 5208: clock cycles per bit (50 MHz / 9600 Bd); legal range ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd; parity bit sits between D7 and stop.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `txdw`  in  8  byte to send; sampled only in the cycle `txrdy`=1.
- `txrdy`  in  1  one-cycle write strobe.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame (start..stop) is on the line.
- `full`  out  1  holding register occupied.
- `done`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `ovr`  out  1  sticky overrun flag; cleared only by reset.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when a byte is available (holding register full, or `txrdy` in IDLE).
  - START -> DATA after 1 bit time.
  - DATA runs 8 bit times, LSB first.
  - DATA -> PARITY if `PARITY`≠0, else DATA -> STOP.
  - PARITY -> STOP after 1 bit time.
  - STOP -> START if the holding register is full, else STOP -> IDLE.
- Bit timer: counts 0..`BAUD_DIV`-1, ceil(log2(`BAUD_DIV`)) bits wide, reloads at every bit boundary. Bit index counter is 3 bits and only advances in DATA.
- Shift register: loaded from `txdw` (IDLE accept) or from the holding register (STOP->START) at frame start.
- Parity bit:
  - even = ^data.
  - odd = ~^data.
  - Computed from the loaded byte, not from live `txdw`.
- Write acceptance (`txrdy`=1):
  - In IDLE with `full`=0: byte goes directly to the shift register.
  - While `busy`=1 with `full`=0: byte is captured into the holding register and `full` goes high.
  - With `full`=1: byte is discarded, `ovr` set, holding register keeps its old value.
- Holding register transfer: at the STOP->START transition its byte moves to the shift register and `full` clears.
- Simultaneous events:
  - `txrdy` in the last cycle of STOP with `full`=0: the byte is captured, and the next frame starts in the following cycle, exactly as if it had been held.
  - `txrdy` in the same cycle as the holding-to-shift transfer: `full` stays high because the new byte fills the freed holding register; no overrun.
- Reset (`rst`=0 at a rising edge), including mid-frame: state IDLE, `tx`=1, `busy`=0, `full`=0, `done`=0, `ovr`=0, counters 0, holding register invalidated. The partial frame is abandoned.

## Timing
- All outputs are registered. Reset values: `tx`=1, `busy`=0, `full`=0, `done`=0, `ovr`=0.
- Latency: `txrdy` sampled at edge N in IDLE -> `tx`=0 and `busy`=1 from edge N+1.
- Each bit holds `tx` for exactly `BAUD_DIV` cycles.
- Frame length F = (10 + (`PARITY`≠0)) × `BAUD_DIV` cycles.
- `done`:
  - Asserted for exactly one cycle, in the cycle after the last stop-bit cycle (edge N+1+F).
  - In the same edge, `busy` drops to 0, or the next start bit begins if a byte is pending.
- Back-to-back frames: the next start bit begins immediately after the stop bit, with no idle cycle; `busy` stays 1 throughout.
- `full`:
  - Rises the edge after the accepting `txrdy`.
  - Falls on the edge where the next frame's start bit begins.
- `ovr` rises the edge after the rejected `txrdy`.
- `txdw` need not be held after the strobe cycle.

## Test plan
- `BAUD_DIV`=4, `PARITY`=0; after reset check `tx`=1 and all flags 0. Pulse `txrdy` with `txdw`=8'hF0 -> `tx` shows 0 (start), 0,0,0,0,1,1,1,1, 1 (stop), 4 cycles each; `done` pulses once 40 cycles after start; `busy` high for exactly 40 cycles.
- `PARITY`=1 with `txdw`=8'h0F -> even parity bit 0, frame 44 cycles. `PARITY`=2 with the same byte -> parity bit 1.
- Send 8'hF0, then 8'h0F 5 cycles later -> `full`=1 until the second start bit; frames contiguous (80 cycles of `busy`=1, no idle gap); two `done` pulses 40 cycles apart.
- With `full`=1, pulse `txrdy` with 8'hAA -> `ovr`=1 and stays 1; 8'hAA never appears on `tx`; the held byte is sent intact.
- `txrdy` in the final stop-bit cycle -> next start bit on the following cycle, no `ovr`.
- Assert `rst`=0 in the middle of DATA -> next edge `tx`=1, `busy`=`full`=`ovr`=0, no `done`. A new byte sent after reset transmits correctly.
